// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: latches an ALU request, runs it directly or through a
// multi-cycle unit with timeout, and commits result/lastresult with a valid pulse.
module alu_op_sequencer #(
   parameter int          TIMEOUT    = 64,
   parameter logic [15:0] MULTI_MASK = 16'h00CC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  op_sel,
   input  logic        go,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   input  logic [63:0] comb_result,
   input  logic        unit_done,
   input  logic        unit_err,
   output logic [3:0]  op_lat,
   output logic [31:0] opa,
   output logic [31:0] opb,
   output logic [31:0] shift_src,
   output logic        unit_start,
   output logic        busy,
   output logic [63:0] result,
   output logic [63:0] lastresult,
   output logic        valid,
   output logic        err
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, EXEC, ISSUE, WAIT} state_t;

   state_t        state_q, state_d;
   logic          go_q;
   logic [3:0]    op_lat_q, op_lat_d;
   logic [31:0]   opa_q, opa_d, opb_q, opb_d;
   logic [63:0]   result_q, result_d, last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d, valid_q, valid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         go_q     <= 1'b1;
         op_lat_q <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         last_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         go_q     <= go;
         op_lat_q <= op_lat_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_lat_d = op_lat_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: if (go && !go_q) begin
            op_lat_d = op_sel;
            opa_d    = num1;
            opb_d    = num2;
            err_d    = 1'b0;
            state_d  = MULTI_MASK[op_sel] ? ISSUE : EXEC;
         end
         EXEC: begin
            last_d   = result_q;
            result_d = comb_result;
            valid_d  = 1'b1;
            state_d  = IDLE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: if (unit_done) begin
            // done wins over a timeout landing on the same edge
            err_d    = unit_err;
            last_d   = unit_err ? last_q : result_q;
            result_d = unit_err ? result_q : comb_result;
            valid_d  = !unit_err;
            state_d  = IDLE;
         end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign op_lat     = op_lat_q;
   assign opa        = opa_q;
   assign opb        = opb_q;
   assign result     = result_q;
   assign lastresult = last_q;
   assign shift_src  = result_q[31:0];
   assign unit_start = (state_q == ISSUE);
   assign busy       = (state_q != IDLE);
   assign valid      = valid_q;
   assign err        = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed stimulus pushes expected commits into a queue;
// a negedge monitor pops and compares on every valid pulse.
module tb_alu_op_sequencer;
   logic        clk = 1'b0;
   logic        rst, go, unit_done, unit_err;
   logic [3:0]  op_sel, op_lat;
   logic [31:0] num1, num2, opa, opb, shift_src;
   logic [63:0] comb_result, result, lastresult;
   logic        unit_start, busy, valid, err;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   logic [127:0] exp_q[$];

   alu_op_sequencer dut (
      .clk(clk), .rst(rst), .op_sel(op_sel), .go(go), .num1(num1), .num2(num2),
      .comb_result(comb_result), .unit_done(unit_done), .unit_err(unit_err),
      .op_lat(op_lat), .opa(opa), .opb(opb), .shift_src(shift_src),
      .unit_start(unit_start), .busy(busy), .result(result),
      .lastresult(lastresult), .valid(valid), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (unit_start) starts++;
      if (valid) begin
         logic [127:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got result %h expected no commit", result);
         end else begin
            e = exp_q.pop_front();
            if ({result, lastresult} !== e) begin
               errors++;
               $display("FAIL commit: got %h/%h expected %h/%h", result, lastresult, e[127:64], e[63:0]);
            end
         end
      end
   end

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_result"}, result, 64'd0);
      chk({tag, "_last"}, lastresult, 64'd0);
      chk({tag, "_oplat_opa_opb"}, {28'd0, op_lat, opa}, 64'd0);
      chk({tag, "_opb"}, 64'(opb), 64'd0);
      chk({tag, "_err_valid_start"}, {61'd0, err, valid, unit_start}, 64'd0);
   endtask

   task automatic request(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      op_sel = op; num1 = a; num2 = b; go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   int s0;

   initial begin
      rst = 1'b1; go = 1'b1; op_sel = '0; num1 = '0; num2 = '0;
      comb_result = '0; unit_done = 1'b0; unit_err = 1'b0;
      tick(2);
      check_idle_zero("reset");
      rst = 1'b0;
      tick(3);
      chk("go_held_no_request", 64'(busy), 64'd0);
      go = 1'b0;
      tick();

      // single-cycle add
      comb_result = 64'd5;
      exp_q.push_back({64'd5, 64'd0});
      request(4'h0, 32'd3, 32'd2);
      chk("add_busy", 64'(busy), 64'd1);
      chk("add_latch", {28'd0, op_lat, opa}, {28'd0, 4'h0, 32'd3});
      chk("add_opb", 64'(opb), 64'd2);
      tick();
      chk("add_commit_busy", 64'(busy), 64'd0);
      chk("add_result", result, 64'd5);
      tick();
      chk("add_valid_drop", 64'(valid), 64'd0);

      // multi-cycle with ignored go edge / operand change during WAIT
      comb_result = 64'h1_0000_0000;
      exp_q.push_back({64'h1_0000_0000, 64'd5});
      s0 = starts;
      request(4'h2, 32'd7, 32'd9);
      chk("mul_start", 64'(unit_start), 64'd1);
      tick();
      go = 1'b1; op_sel = 4'h5; num1 = 32'hFFFF;
      for (int i = 2; i <= 5; i++) begin
         chk("mul_busy", 64'(busy), 64'd1);
         tick();
      end
      unit_done = 1'b1;
      tick();
      unit_done = 1'b0;
      chk("mul_done_busy", 64'(busy), 64'd0);
      chk("mul_oplat_opa", {28'd0, op_lat, opa}, {28'd0, 4'h2, 32'd7});
      chk("mul_start_once", 64'(starts - s0), 64'd1);
      tick();
      chk("go_held_no_retrigger", 64'(busy), 64'd0);
      go = 1'b0;
      tick();

      // unit error
      request(4'h3, 32'd1, 32'd0);
      tick();
      unit_done = 1'b1; unit_err = 1'b1;
      tick();
      unit_done = 1'b0; unit_err = 1'b0;
      chk("uerr_err", 64'(err), 64'd1);
      chk("uerr_result", result, 64'h1_0000_0000);
      chk("uerr_last", lastresult, 64'd5);
      tick();

      // timeout after 64 WAIT cycles; request clears err
      request(4'h3, 32'd1, 32'd0);
      chk("req_clears_err", 64'(err), 64'd0);
      tick();
      tick(63);
      chk("to_last_cycle_busy", 64'(busy), 64'd1);
      tick();
      chk("to_err", 64'(err), 64'd1);
      chk("to_busy", 64'(busy), 64'd0);
      chk("to_result", result, 64'h1_0000_0000);
      tick();

      // done on the timeout edge wins
      comb_result = 64'h0000_0000_CAFE_F00D;
      exp_q.push_back({64'h0000_0000_CAFE_F00D, 64'h1_0000_0000});
      request(4'h6, 32'd4, 32'd4);
      tick();
      tick(63);
      unit_done = 1'b1;
      tick();
      unit_done = 1'b0;
      chk("done_at_timeout_err", 64'(err), 64'd0);
      chk("shift_src", 64'(shift_src), 64'hCAFE_F00D);

      // unit_done in IDLE is ignored
      comb_result = 64'h99;
      unit_done = 1'b1;
      tick(2);
      unit_done = 1'b0;
      chk("idle_done_result", result, 64'h0000_0000_CAFE_F00D);

      // op 15 is single-cycle under the default mask
      comb_result = 64'h123;
      exp_q.push_back({64'h123, 64'h0000_0000_CAFE_F00D});
      request(4'hF, 32'd1, 32'd1);
      tick();
      chk("circ_result", result, 64'h123);
      tick();

      // reset mid-WAIT, then a late unit_done
      request(4'h7, 32'd5, 32'd6);
      tick(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      unit_done = 1'b1;
      tick(2);
      unit_done = 1'b0;
      check_idle_zero("midwait_reset");
      tick(2);

      chk("pending_commits", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
